// File: rtl/sr_input_conditioner_pkg.sv
// rtl/sr_input_conditioner_pkg.sv - shared types and helpers for the SR input conditioner
package sr_cond_pkg;

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } dbnc_state_t;

    function automatic int cnt_width(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sr_input_conditioner_if.sv
// rtl/sr_input_conditioner_if.sv - raw button inputs and clean latch commands
interface sr_input_conditioner_if;
    logic s_raw;
    logic r_raw;
    logic s;
    logic r;
    logic conflict;

    modport master (output s_raw, output r_raw, input s, input r, input conflict);
    modport slave  (input s_raw, input r_raw, output s, output r, output conflict);
endinterface

// File: rtl/sr_input_conditioner_dbnc_channel.sv
// rtl/sr_input_conditioner_dbnc_channel.sv - synchroniser plus debounce FSM for one raw input
module dbnc_channel
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt;
    dbnc_state_t            state;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // cnt holds the number of stable samples already seen; the sample that
    // brings it to DEBOUNCE_CYCLES commits the level without a further cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            unique case (state)
                LO: begin
                    if (sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= HI;
                            level <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= CHK_HI;
                            cnt   <= CW'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!sync) begin
                        state <= LO;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HI;
                        level <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HI: begin
                    if (!sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= LO;
                            level <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= CHK_LO;
                            cnt   <= CW'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (sync) begin
                        state <= HI;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= LO;
                        level <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sr_input_conditioner.sv
// rtl/sr_input_conditioner.sv - debounced set/reset commands for an SR latch; SR_COND_PULSE_EN selects edge-pulse commands
module sr_input_conditioner
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_WINS      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sr_input_conditioner_if.slave bus
);
    logic s_lvl;
    logic r_lvl;
    logic cmd_s;
    logic cmd_r;
    logic res_s;
    logic res_r;

    dbnc_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.s_raw),
        .level (s_lvl)
    );

    dbnc_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.r_raw),
        .level (r_lvl)
    );

`ifdef SR_COND_PULSE_EN
    logic s_lvl_q;
    logic r_lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_lvl_q <= 1'b0;
            r_lvl_q <= 1'b0;
        end else begin
            s_lvl_q <= s_lvl;
            r_lvl_q <= r_lvl;
        end
    end

    assign cmd_s = s_lvl & ~s_lvl_q;
    assign cmd_r = r_lvl & ~r_lvl_q;
`else
    assign cmd_s = s_lvl;
    assign cmd_r = r_lvl;
`endif

    // Never let 2'b11 reach the latch: either reset wins or both drop so it holds.
    always_comb begin
        res_s = cmd_s;
        res_r = cmd_r;
        if (cmd_s && cmd_r) begin
            res_s = 1'b0;
            res_r = (RESET_WINS != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.s        <= 1'b0;
            bus.r        <= 1'b0;
            bus.conflict <= 1'b0;
        end else begin
            bus.s        <= res_s;
            bus.r        <= res_r;
            bus.conflict <= s_lvl & r_lvl;
        end
    end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb/tb_sr_input_conditioner.sv - scoreboard bench for sr_input_conditioner under both conflict policies
module tb_sr_input_conditioner;

`ifdef SR_COND_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif
    // value of a command while its debounced level stays high after the first cycle
    localparam logic LV = PULSE ? 1'b0 : 1'b1;
    // RESET_WINS=0 reset output when r rises while s is already held
    localparam logic RHELD0 = PULSE ? 1'b1 : 1'b0;

    typedef struct {
        logic s;
        logic r1;
        logic r0;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_raw = 1'b1;
    logic r_raw = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    sr_input_conditioner_if bus1 ();
    sr_input_conditioner_if bus0 ();

    assign bus1.s_raw = s_raw;
    assign bus1.r_raw = r_raw;
    assign bus0.s_raw = s_raw;
    assign bus0.r_raw = r_raw;

    sr_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_WINS(1)) dut_rw1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    sr_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_WINS(0)) dut_rw0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cycle, act, req);
        end
    endtask

    task automatic hold(input int n, input logic rv, input logic sv, input logic rrv,
                        input logic es, input logic er1, input logic er0, input logic ec);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = rv;
            s_raw = sv;
            r_raw = rrv;
            e.s  = es;
            e.r1 = er1;
            e.r0 = er0;
            e.c  = ec;
            q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rw1_s",        bus1.s,        e.s);
                chk("rw1_r",        bus1.r,        e.r1);
                chk("rw1_conflict", bus1.conflict, e.c);
                chk("rw0_s",        bus0.s,        e.s);
                chk("rw0_r",        bus0.r,        e.r0);
                chk("rw0_conflict", bus0.conflict, e.c);
                chk("rw1_not_both", bus1.s && bus1.r, 1'b0);
                chk("rw0_not_both", bus0.s && bus0.r, 1'b0);
                cycle++;
            end
        end
    end

    initial begin : stimulus
        int drain;
        // reset with both buttons held, then both accepted together
        hold(3, 0, 1, 1, 0, 0, 0, 0);
        hold(6, 1, 1, 1, 0, 0, 0, 0);
        hold(1, 1, 1, 1, 0, 1, 0, 1);
        hold(3, 1, 1, 1, 0, LV, 0, 1);
        hold(6, 1, 0, 0, 0, LV, 0, 1);
        hold(2, 1, 0, 0, 0, 0, 0, 0);
        // clean set, then release
        hold(6, 1, 1, 0, 0, 0, 0, 0);
        hold(1, 1, 1, 0, 1, 0, 0, 0);
        hold(3, 1, 1, 0, LV, 0, 0, 0);
        hold(6, 1, 0, 0, LV, 0, 0, 0);
        hold(2, 1, 0, 0, 0, 0, 0, 0);
        // bounce with 3-cycle runs is rejected, then a stable press is accepted
        for (int p = 0; p < 5; p++) begin
            hold(3, 1, 1, 0, 0, 0, 0, 0);
            hold(3, 1, 0, 0, 0, 0, 0, 0);
        end
        hold(6, 1, 1, 0, 0, 0, 0, 0);
        hold(1, 1, 1, 0, 1, 0, 0, 0);
        hold(3, 1, 1, 0, LV, 0, 0, 0);
        hold(6, 1, 0, 0, LV, 0, 0, 0);
        hold(2, 1, 0, 0, 0, 0, 0, 0);
        // reset while the set channel is mid-debounce at cnt=3
        hold(5, 1, 1, 0, 0, 0, 0, 0);
        hold(2, 0, 1, 0, 0, 0, 0, 0);
        hold(6, 1, 1, 0, 0, 0, 0, 0);
        hold(1, 1, 1, 0, 1, 0, 0, 0);
        hold(2, 1, 1, 0, LV, 0, 0, 0);
        hold(6, 1, 0, 0, LV, 0, 0, 0);
        hold(2, 1, 0, 0, 0, 0, 0, 0);
        // long set hold, then hand over to a long reset hold
        hold(6, 1, 1, 0, 0, 0, 0, 0);
        hold(1, 1, 1, 0, 1, 0, 0, 0);
        hold(43, 1, 1, 0, LV, 0, 0, 0);
        hold(6, 1, 0, 1, LV, 0, 0, 0);
        hold(1, 1, 0, 1, 0, 1, 1, 0);
        hold(20, 1, 0, 1, 0, LV, LV, 0);
        hold(6, 1, 0, 0, 0, LV, LV, 0);
        hold(2, 1, 0, 0, 0, 0, 0, 0);
        // reset pressed while set is already held
        hold(6, 1, 1, 0, 0, 0, 0, 0);
        hold(1, 1, 1, 0, 1, 0, 0, 0);
        hold(5, 1, 1, 0, LV, 0, 0, 0);
        hold(6, 1, 1, 1, LV, 0, 0, 0);
        hold(1, 1, 1, 1, 0, 1, RHELD0, 1);
        hold(3, 1, 1, 1, 0, LV, 0, 1);
        hold(6, 1, 0, 0, 0, LV, 0, 1);
        hold(2, 1, 0, 0, 0, 0, 0, 0);

        drain = 0;
        while (q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
